// File: rtl/hconv_stream_filter.sv
// Horizontal 3-tap stream filter: one pass per start over an IMG_W x IMG_H frame,
// edge-replicated window, four modes (pass, clamped gradient, abs gradient, smoothing).
module hconv_stream_filter #(
    parameter int IMG_W       = 640,
    parameter int IMG_H       = 480,
    parameter int PIX_W       = 8,
    parameter int START_DELAY = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic             in_avail,
    input  logic             out_ready,
    output logic             read_request,
    input  logic [PIX_W-1:0] pixel_i,
    output logic             write_request,
    output logic [PIX_W-1:0] pixel_o,
    output logic             finished,
    output logic             busy
);
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int DW = (START_DELAY > 1) ? $clog2(START_DELAY + 1) : 1;
    localparam int SW = PIX_W + 2;
    localparam logic signed [SW-1:0] MAX = SW'((1 << PIX_W) - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef enum logic [2:0] {S_IDLE, S_DELAY, S_RUN, S_DRAIN, S_DONE} state_t;
    localparam state_t LAUNCH = (START_DELAY == 0) ? S_RUN : S_DELAY;

    state_t            state, state_nxt;
    logic [DW-1:0]     dly_cnt;
    logic [1:0]        drain_cnt;
    logic [CW-1:0]     col, dcol;
    logic [RW-1:0]     row;
    logic [1:0]        mode_q;
    logic              dvalid, flush;
    logic [PIX_W-1:0]  l_pix, c_pix, win_r, res;
    logic signed [SW-1:0] sl, sr, diff, mag;
    logic [SW-1:0]     sum;
    logic              start_ok, last_read, emit;

    assign start_ok  = start && (state == S_IDLE || state == S_DONE);
    assign last_read = read_request && col == COL_LAST && row == ROW_LAST;

    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_nxt = LAUNCH;
            S_DELAY:        if (dly_cnt <= DW'(1)) state_nxt = S_RUN;
            S_RUN:          if (last_read) state_nxt = S_DRAIN;
            S_DRAIN:        if (drain_cnt == 2'd2) state_nxt = S_DONE;
            default:        state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        read_request = (state == S_RUN) && in_avail && out_ready;
        busy         = (state == S_DELAY) || (state == S_RUN) || (state == S_DRAIN);
        finished     = (state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            dly_cnt   <= '0;
            drain_cnt <= '0;
            col       <= '0;
            row       <= '0;
            dcol      <= '0;
            mode_q    <= '0;
            dvalid    <= 1'b0;
            flush     <= 1'b0;
        end else begin
            if (start_ok) begin
                dly_cnt <= DW'(START_DELAY);
                mode_q  <= mode;
                col     <= '0;
                row     <= '0;
                dcol    <= '0;
            end else begin
                if (state == S_DELAY) dly_cnt <= dly_cnt - DW'(1);
                if (read_request) begin
                    if (col == COL_LAST) begin
                        col <= '0;
                        row <= (row == ROW_LAST) ? '0 : row + RW'(1);
                    end else begin
                        col <= col + CW'(1);
                    end
                end
                if (dvalid) dcol <= (dcol == COL_LAST) ? '0 : dcol + CW'(1);
            end
            drain_cnt <= (state == S_DRAIN) ? drain_cnt + 2'd1 : 2'd0;
            dvalid    <= read_request;
            flush     <= dvalid && dcol == COL_LAST;
        end
    end

    // Flush replicates the right edge; it can never coincide with a column>=1 arrival.
    assign emit  = (dvalid && dcol != '0) || flush;
    assign win_r = flush ? c_pix : pixel_i;

    always_comb begin
        sl   = $signed({2'b00, l_pix});
        sr   = $signed({2'b00, win_r});
        diff = sr - sl;
        mag  = diff[SW-1] ? -diff : diff;
        sum  = {2'b00, l_pix} + {1'b0, c_pix, 1'b0} + {2'b00, win_r} + SW'(2);
        res  = c_pix;
        case (mode_q)
            2'd1: begin
                if (diff < 0)        res = '0;
                else if (diff > MAX) res = MAX[PIX_W-1:0];
                else                 res = diff[PIX_W-1:0];
            end
            2'd2: res = (mag > MAX) ? MAX[PIX_W-1:0] : mag[PIX_W-1:0];
            2'd3: res = sum[SW-1:2];
            default: res = c_pix;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            l_pix         <= '0;
            c_pix         <= '0;
            write_request <= 1'b0;
            pixel_o       <= '0;
        end else begin
            write_request <= emit;
            if (emit) pixel_o <= res;
            if (dvalid) begin
                l_pix <= (dcol == '0) ? pixel_i : c_pix;
                c_pix <= pixel_i;
            end
        end
    end
endmodule

// File: tb/tb_hconv_stream_filter.sv
// Directed bench for hconv_stream_filter on an 8x2 frame with a short start delay.
module tb_hconv_stream_filter;
    localparam int W = 8;
    localparam int H = 2;
    localparam int N = W * H;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset, start, in_avail, out_ready;
    logic [1:0] mode;
    logic       read_request, write_request, finished, busy;
    logic [7:0] pixel_i = '0;
    logic [7:0] pixel_o;

    hconv_stream_filter #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .START_DELAY(D)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .in_avail(in_avail), .out_ready(out_ready), .read_request(read_request),
        .pixel_i(pixel_i), .write_request(write_request), .pixel_o(pixel_o),
        .finished(finished), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] src [N];
    logic [7:0] exp_px [N];
    logic       clr = 1'b0;
    int         rd_n = 0;

    // Upstream FIFO: data appears the cycle after a pop.
    always @(posedge clk) begin
        if (clr) rd_n <= 0;
        else if (read_request) begin
            if (rd_n < N) pixel_i <= src[rd_n];
            rd_n <= rd_n + 1;
        end
    end

    int nrd = 0, nwr = 0, first_rd = 0, last_rd = 0, first_wr = 0, last_wr = 0;
    int fin_cyc = -1, viol = 0;
    logic fin_prev = 1'b0;
    logic [7:0] out_q [$];

    always @(negedge clk) begin
        if (clr) begin
            nrd = 0; nwr = 0; viol = 0; fin_cyc = -1;
            out_q.delete();
        end else begin
            if (read_request) begin
                if (nrd == 0) first_rd = cyc;
                last_rd = cyc;
                nrd++;
                if (!in_avail || !out_ready) viol++;
            end
            if (write_request) begin
                if (nwr == 0) first_wr = cyc;
                last_wr = cyc;
                nwr++;
                out_q.push_back(pixel_o);
            end
            if (finished && !fin_prev && fin_cyc < 0) fin_cyc = cyc;
        end
        fin_prev = finished;
    end

    int checks = 0, fails = 0, st_cyc = 0;

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic clear_mon;
        clr = 1'b1; tick; clr = 1'b0;
    endtask

    task automatic do_start(input logic [1:0] m);
        start = 1'b1; mode = m; st_cyc = cyc;
        tick;
        start = 1'b0;
    endtask

    task automatic wait_fin(input string nm);
        int k = 0;
        while (!finished && k < 2000) begin tick; k++; end
        checks++;
        if (!finished) begin
            fails++;
            $display("FAIL %s: finished not seen within budget, got %0b want 1", nm, finished);
        end
        tick;
    endtask

    task automatic wait_reads(input int n, input string nm);
        int k = 0;
        while (nrd < n && k < 500) begin tick; k++; end
        checks++;
        if (nrd < n) begin
            fails++;
            $display("FAIL %s: reads got %0d want >=%0d", nm, nrd, n);
        end
    endtask

    task automatic check_frame(input string nm);
        checks++;
        if (nrd !== N) begin fails++; $display("FAIL %s reads: got %0d want %0d", nm, nrd, N); end
        checks++;
        if (nwr !== N) begin fails++; $display("FAIL %s writes: got %0d want %0d", nm, nwr, N); end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (i >= out_q.size()) begin
                fails++; $display("FAIL %s px%0d: missing, want %0d", nm, i, exp_px[i]);
            end else if (out_q[i] !== exp_px[i]) begin
                fails++; $display("FAIL %s px%0d: got %0d want %0d", nm, i, out_q[i], exp_px[i]);
            end
        end
    endtask

    task automatic load_ramp;
        for (int i = 0; i < N; i++) begin src[i] = 8'(i); exp_px[i] = 8'(i); end
    endtask

    task automatic load_abs;
        src    = '{200, 0, 255, 0, 200, 0, 255, 0, 255, 0, 0, 0, 0, 0, 0, 255};
        exp_px = '{200, 55, 0, 55, 0, 55, 0, 255, 255, 255, 0, 0, 0, 0, 255, 255};
    endtask

    task automatic load_clamp;
        src    = '{10, 20, 30, 40, 50, 60, 70, 80, 80, 70, 60, 50, 40, 30, 20, 10};
        exp_px = '{10, 20, 20, 20, 20, 20, 20, 10, 0, 0, 0, 0, 0, 0, 0, 0};
    endtask

    task automatic load_smooth;
        src    = '{0, 0, 255, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 255};
        exp_px = '{0, 64, 128, 64, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 64, 191};
    endtask

    task automatic test_reset;
        reset = 1'b0; start = 1'b0; mode = 2'd0; in_avail = 1'b1; out_ready = 1'b1;
        tick; tick;
        checks++; if (read_request !== 1'b0) begin fails++; $display("FAIL rst read_request: got %b want 0", read_request); end
        checks++; if (write_request !== 1'b0) begin fails++; $display("FAIL rst write_request: got %b want 0", write_request); end
        checks++; if (pixel_o !== 8'd0) begin fails++; $display("FAIL rst pixel_o: got %0d want 0", pixel_o); end
        checks++; if (finished !== 1'b0) begin fails++; $display("FAIL rst finished: got %b want 0", finished); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rst busy: got %b want 0", busy); end
        reset = 1'b1;
        tick;
    endtask

    task automatic test_pass_ramp;
        load_ramp; clear_mon; do_start(2'd0);
        wait_fin("pass");
        check_frame("pass");
        checks++; if (first_rd - st_cyc !== D + 1) begin fails++; $display("FAIL pass first read delay: got %0d want %0d", first_rd - st_cyc, D + 1); end
        checks++; if (first_wr - first_rd !== 3) begin fails++; $display("FAIL pass first write lag: got %0d want 3", first_wr - first_rd); end
        checks++; if (last_wr - last_rd !== 3) begin fails++; $display("FAIL pass last write lag: got %0d want 3", last_wr - last_rd); end
        checks++; if (fin_cyc - last_rd !== 4) begin fails++; $display("FAIL pass finished lag: got %0d want 4", fin_cyc - last_rd); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL pass busy in done: got %b want 0", busy); end
    endtask

    task automatic test_clamp;
        load_clamp; clear_mon; do_start(2'd1);
        wait_fin("clamp");
        check_frame("clamp");
    endtask

    task automatic test_abs;
        load_abs; clear_mon; do_start(2'd2);
        wait_fin("abs");
        check_frame("abs");
    endtask

    task automatic test_smooth;
        load_smooth; clear_mon; do_start(2'd3);
        wait_fin("smooth");
        check_frame("smooth");
    endtask

    task automatic test_stall;
        int k = 0, low = 0;
        load_abs; clear_mon; do_start(2'd2);
        while (!finished && k < 3000) begin
            in_avail = ($urandom_range(0, 3) != 0);
            if (nrd >= 3 && low < 20) begin out_ready = 1'b0; low++; end
            else out_ready = 1'b1;
            tick; k++;
        end
        in_avail = 1'b1; out_ready = 1'b1;
        wait_fin("stall");
        check_frame("stall");
        checks++; if (viol !== 0) begin fails++; $display("FAIL stall gated reads: got %0d illegal want 0", viol); end
    endtask

    task automatic test_start_ignored;
        load_clamp; clear_mon; do_start(2'd1);
        wait_reads(5, "ignore");
        start = 1'b1; mode = 2'd3;
        tick;
        start = 1'b0;
        wait_fin("ignore");
        check_frame("ignore");
    endtask

    task automatic test_back_to_back;
        load_smooth; clear_mon; do_start(2'd3);
        wait_fin("b2b");
        check_frame("b2b");
        checks++; if (first_rd - st_cyc !== D + 1) begin fails++; $display("FAIL b2b first read delay: got %0d want %0d", first_rd - st_cyc, D + 1); end
    endtask

    task automatic test_reset_mid;
        int r0, w0;
        load_ramp; clear_mon; do_start(2'd0);
        wait_reads(6, "rstmid");
        reset = 1'b0;
        tick;
        reset = 1'b1;
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid busy: got %b want 0", busy); end
        checks++; if (read_request !== 1'b0) begin fails++; $display("FAIL rstmid read_request: got %b want 0", read_request); end
        checks++; if (write_request !== 1'b0) begin fails++; $display("FAIL rstmid write_request: got %b want 0", write_request); end
        checks++; if (pixel_o !== 8'd0) begin fails++; $display("FAIL rstmid pixel_o: got %0d want 0", pixel_o); end
        checks++; if (finished !== 1'b0) begin fails++; $display("FAIL rstmid finished: got %b want 0", finished); end
        tick;
        r0 = nrd; w0 = nwr;
        repeat (10) tick;
        checks++; if (nrd !== r0 || nwr !== w0) begin fails++; $display("FAIL rstmid activity: got %0d/%0d want %0d/%0d", nrd, nwr, r0, w0); end
        clear_mon; do_start(2'd0);
        wait_fin("rstmid_restart");
        check_frame("rstmid_restart");
    endtask

    initial begin
        test_reset;
        test_pass_ramp;
        test_clamp;
        test_abs;
        test_smooth;
        test_stall;
        test_start_ignored;
        test_back_to_back;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/hconv_stream_filter.md
# hconv_stream_filter

Parametrised horizontal 3-tap stream filter for the image-processing chain. It sits between a frame-buffer read FIFO and a write FIFO and runs one pass over a frame per `start`. Relative to the fixed 640x480 difference filter it adds:
- configurable frame geometry and pixel width;
- four run-time modes;
- edge replication at row boundaries;
- upstream/downstream back-pressure;
- re-triggerable frames.

## Interface
- `IMG_W`, 640: pixels per row (≥2).
- `IMG_H`, 480: rows per frame (≥1).
- `PIX_W`, 8: pixel width in bits.
- `START_DELAY`, 255: idle cycles between `start` and the first read.
- `clk`  in  1: single clock; all logic on its rising edge.
- `reset`  in  1: synchronous, active-low reset. `reset`=0 at a rising edge resets the block.
- `start`  in  1: single-cycle frame trigger. Accepted only in IDLE or DONE.
- `mode`  in  2: 0 pass, 1 clamped gradient, 2 absolute gradient, 3 smoothing. Sampled when `start` is accepted.
- `in_avail`  in  1: upstream FIFO not empty.
- `out_ready`  in  1: downstream FIFO can accept ≥3 more words (inverted almost-full).
- `read_request`  out  1: pop one pixel from upstream.
- `pixel_i`  in  PIX_W: upstream data, valid in the cycle after `read_request`.
- `write_request`  out  1: push `pixel_o` downstream.
- `pixel_o`  out  PIX_W: filtered pixel (registered).
- `finished`  out  1: high while in DONE.
- `busy`  out  1: high in DELAY, RUN and DRAIN.

## Operation
- FSM states: IDLE, DELAY, RUN, DRAIN, DONE.
  - IDLE→DELAY on `start`.
  - DELAY: counter loads `START_DELAY`, decrements; →RUN when it reaches 0.
  - RUN→DRAIN in the cycle the last read of the frame (row IMG_H-1, col IMG_W-1) is issued.
  - DRAIN holds 3 cycles, then →DONE.
  - DONE→DELAY on `start`.
- `read_request` = RUN & `in_avail` & `out_ready`. Gaps of any length are legal. Exactly IMG_W*IMG_H reads and IMG_W*IMG_H writes per frame.
- Counters:
  - Read-side col/row counters advance per read.
  - Data-side column counter `dcol` advances on `dvalid` (= `read_request` delayed 1) and wraps at IMG_W-1 to 0.
- Window registers L, C:
  - Column 0 arrival: L←C←p (left edge replicated). No output.
  - Column c≥1 arrival: emit column c-1 from (L, C, R=p), then L←C, C←p. For column 0 output, L equals C.
  - `flush` = (`dvalid` & `dcol`==IMG_W-1) delayed 1. In the flush cycle, emit column IMG_W-1 from (L, C, R=C) (right edge replicated).
  - The flush cycle never collides with an output: a simultaneous next-row column-0 arrival emits nothing. Flush reads L, C before they are overwritten.
- Arithmetic, internal width PIX_W+2 signed, MAX = 2^PIX_W−1:
  - mode 0: C.
  - mode 1: R−L; negative → 0; >MAX → MAX.
  - mode 2: |R−L|, saturated to MAX.
  - mode 3: (L + 2C + R + 2) >> 2 (rounded; never exceeds MAX).
- `mode` is latched at `start`. Changes mid-frame have no effect.
- `start` in DELAY, RUN or DRAIN is ignored.

## Timing
- Reset values: `read_request`=0, `write_request`=0, `pixel_o`=0, `finished`=0, `busy`=0, state IDLE, all counters 0.
- First read occurs START_DELAY+1 cycles after the `start` cycle.
- Column c<IMG_W-1: `write_request`/`pixel_o` are high/valid in cycle t+1, where t is the cycle pixel c+1 is on `pixel_i`.
- Column IMG_W-1: written in t+2, where t is the cycle its own pixel is on `pixel_i`.
- With no stalls, the first write comes 3 cycles after the first read, and the last write comes 3 cycles after the last read.
- `finished` rises the cycle after the last write.
- The `out_ready` margin of 3 covers the in-flight words. `write_request` is never gated by `out_ready`.
- Reset (0) mid-frame: next cycle is IDLE, all outputs 0, and no further reads or writes. Upstream FIFO contents are not flushed by this block.

## Test plan
- IMG_W=8, IMG_H=2, START_DELAY=4, mode 0, ramp 0..15, no stalls → first `read_request` 5 cycles after `start`. Outputs 0..15 in order, 16 writes. `finished` rises 4 cycles after the last read.
- mode 1, row 10,20,30,40,50,60,70,80 → 10,20,20,20,20,20,20,10 (edges replicated). Descending row → all 0.
- mode 2, row 200,0,255,0,... → |R−L| saturates at 255, none wraps. mode 3, row 0,0,255,0,0 → 0,64,128,64,0.
- `in_avail` toggled randomly, `out_ready` low for 20 cycles mid-row → exactly IMG_W*IMG_H reads/writes. No read while either input is low. Output stream matches the unstalled reference.
- Reset held low for 1 cycle mid-RUN → IDLE, all outputs 0 next cycle. A new `start` produces a complete correct frame.
- `start` asserted during RUN → ignored. `start` in DONE with a new `mode` → second frame in the new mode. `mode` changed mid-frame → no effect.
